// File: rtl/conv_window_gen.sv
// Sliding KxK window generator for a raster-scan pixel stream.
// K-1 line buffers feed a KxK shift array; completed windows are held under valid/ready.
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 7,
  parameter int PW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PW-1:0]       pix_in,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic                pix_ready,
  output logic [K*K*PW-1:0]   win,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                win_last,
  output logic                frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW = K * K * PW;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(K - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(K - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          accept, emit, pix_last;

  logic [PW-1:0] lb_mem [K-1][IMG_W];
  logic [PW-1:0] lb_out [K-1];

  logic [WW-1:0] arr_q, arr_d;
  logic [WW-1:0] win_q;
  logic          win_valid_q, win_last_q, frame_done_q;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign cur_col  = pix_sof ? '0 : col_q;
  assign cur_row  = pix_sof ? '0 : row_q;
  assign pix_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign emit     = accept && (cur_row >= ROW_EDGE) && (cur_col >= COL_EDGE);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      lb_out[j] = lb_mem[j][cur_col];
    end
  end

  // Line 0 is the oldest row; each accept cascades one column toward it.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < K - 2; j++) begin
        lb_mem[j][cur_col] <= lb_mem[j+1][cur_col];
      end
      lb_mem[K-2][cur_col] <= pix_in;
    end
  end

  always_comb begin
    arr_d = arr_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        arr_d[(r*K+c)*PW +: PW] = arr_q[(r*K+c+1)*PW +: PW];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      arr_d[(r*K+K-1)*PW +: PW] = lb_out[r];
    end
    arr_d[((K-1)*K+K-1)*PW +: PW] = pix_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      arr_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= accept && pix_last;
      if (accept) begin
        arr_q <= arr_d;
      end
      // A fresh load wins over a same-cycle consume.
      if (emit) begin
        win_q       <= arr_d;
        win_valid_q <= 1'b1;
        win_last_q  <= pix_last;
      end else if (win_valid_q && win_ready) begin
        win_valid_q <= 1'b0;
        win_last_q  <= 1'b0;
      end
    end
  end

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a pixel-image model predicts every window,
// which is queued at accept time and compared when the DUT hands it over.
module tb_conv_window_gen;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int K  = 7;
  localparam int PW = 8;
  localparam int WW = K * K * PW;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] pix_in;
  logic          pix_valid, pix_sof, pix_ready;
  logic [WW-1:0] win;
  logic          win_valid, win_ready, win_last, frame_done;

  always #5 clk = ~clk;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .PW(PW)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .win(win), .win_valid(win_valid), .win_ready(win_ready),
    .win_last(win_last), .frame_done(frame_done)
  );

  typedef struct {
    logic [WW-1:0] w;
    logic          last;
  } exp_t;

  exp_t          q[$];
  logic [PW-1:0] img [H][W];
  int            errors = 0, checks = 0;
  int            mrow = 0, mcol = 0, cyc = 0;
  logic          fd_pend = 1'b0, prev_stall = 1'b0;
  int            win_cnt = 0, last_cnt = 0, fd_cnt = 0;
  int            acc66 = -1, first_cyc = -1;
  logic          got_first = 1'b0;
  logic [WW-1:0] first_win = '0;
  logic          acc;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] crop(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*PW +: PW] = img[r-K+1+i][c-K+1+j];
    return w;
  endfunction

  // One clock cycle: drive after the edge, observe and score at the falling edge.
  task automatic step(input logic pv, input logic [PW-1:0] px, input logic sof,
                      input logic wr, output logic accepted);
    exp_t e;
    int   r, c;
    @(posedge clk);
    #1;
    pix_valid = pv; pix_in = px; pix_sof = sof; win_ready = wr;
    @(negedge clk);
    cyc++;
    chk("frame_done", WW'(frame_done), WW'(fd_pend));
    if (frame_done) fd_cnt++;
    if (prev_stall) chk("win_valid_hold", WW'(win_valid), WW'(1'b1));
    prev_stall = win_valid && !wr;
    if (win_valid && first_cyc < 0) first_cyc = cyc;
    if (win_valid && wr) begin
      if (q.size() == 0) chk("unexpected_window", WW'(win_valid), WW'(1'b0));
      else begin
        e = q.pop_front();
        chk("win", win, e.w);
        chk("win_last", WW'(win_last), WW'(e.last));
        if (!got_first) begin first_win = win; got_first = 1'b1; end
        win_cnt++;
        if (e.last) last_cnt++;
      end
    end
    fd_pend  = 1'b0;
    accepted = pv && pix_ready;
    if (accepted) begin
      r = sof ? 0 : mrow;
      c = sof ? 0 : mcol;
      img[r][c] = px;
      if (r >= K-1 && c >= K-1) begin
        e.w = crop(r, c);
        e.last = (r == H-1) && (c == W-1);
        q.push_back(e);
        if (r == K-1 && c == K-1 && acc66 < 0) acc66 = cyc;
      end
      fd_pend = (r == H-1) && (c == W-1);
      if (c == W-1) begin
        mcol = 0;
        mrow = (r == H-1) ? 0 : r + 1;
      end else begin
        mcol = c + 1;
        mrow = r;
      end
    end
  endtask

  task automatic send_frame(input int off, input int npix, input logic sof0,
                            input int pv_pct, input int wr_pct, input logic stall);
    int   nstall, tries, v;
    logic pv, wr, a;
    nstall = 0;
    for (int p = 0; p < npix; p++) begin
      v = ((p / W) * W + (p % W) + off) & 255;
      tries = 0;
      do begin
        pv = int'($urandom_range(99)) < pv_pct;
        wr = (stall && nstall < 10) ? 1'b0 : (int'($urandom_range(99)) < wr_pct);
        step(pv, v[PW-1:0], sof0 && (p == 0), wr, a);
        if (stall && nstall < 10 && win_valid) begin
          chk("stall_pix_ready", WW'(pix_ready), WW'(1'b0));
          if (q.size() > 0) chk("stall_win", win, q[0].w);
          nstall++;
        end
        tries++;
      end while (!a && tries < 200);
      if (!a) chki("pixel_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    int   n;
    logic a;
    n = 0;
    while ((q.size() > 0 || fd_pend) && n < 100) begin
      step(1'b0, '0, 1'b0, 1'b1, a);
      n++;
    end
    chki("drain_empty", q.size(), 0);
  endtask

  task automatic clear_counts();
    win_cnt = 0; last_cnt = 0; fd_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_in = '0; pix_sof = 1'b0; win_ready = 1'b0;
    #12;
    chk("rst_win_valid", WW'(win_valid), '0);
    chk("rst_win", win, '0);
    chk("rst_win_last", WW'(win_last), '0);
    chk("rst_frame_done", WW'(frame_done), '0);
    chk("rst_pix_ready", WW'(pix_ready), WW'(1'b1));
    @(posedge clk); #1 rst = 1'b0;

    // Ramp frame, no bubbles.
    clear_counts();
    send_frame(0, W*H, 1'b1, 100, 100, 1'b0);
    drain();
    chki("ramp_windows", win_cnt, 484);
    chki("ramp_last", last_cnt, 1);
    chki("ramp_frame_done", fd_cnt, 1);
    chki("first_latency", first_cyc - acc66, 1);
    chk("first_e0", WW'(first_win[0*PW +: PW]), WW'(0));
    chk("first_e6", WW'(first_win[6*PW +: PW]), WW'(6));
    chk("first_e7", WW'(first_win[7*PW +: PW]), WW'(28));
    chk("first_e48", WW'(first_win[48*PW +: PW]), WW'(174));

    // Backpressure at the first window.
    clear_counts();
    send_frame(5, W*H, 1'b1, 100, 100, 1'b1);
    drain();
    chki("bp_windows", win_cnt, 484);

    // Random bubbles on both sides.
    clear_counts();
    send_frame(0, W*H, 1'b1, 50, 30, 1'b0);
    drain();
    chki("rand_windows", win_cnt, 484);
    chki("rand_last", last_cnt, 1);

    // Back-to-back frames with different ramps.
    clear_counts();
    send_frame(10, W*H, 1'b1, 100, 100, 1'b0);
    send_frame(99, W*H, 1'b1, 70, 60, 1'b0);
    drain();
    chki("b2b_windows", win_cnt, 968);
    chki("b2b_last", last_cnt, 2);
    chki("b2b_frame_done", fd_cnt, 2);

    // Mid-frame resync via pix_sof.
    clear_counts();
    send_frame(3, 100, 1'b1, 100, 100, 1'b0);
    chki("midsof_no_window", win_cnt + q.size(), 0);
    acc66 = -1; first_cyc = -1;
    send_frame(50, W*H, 1'b1, 100, 100, 1'b0);
    drain();
    chki("midsof_latency", first_cyc - acc66, 1);
    chki("midsof_windows", win_cnt, 484);
    chki("midsof_frame_done", fd_cnt, 1);

    // Reset with a window pending.
    clear_counts();
    send_frame(20, 300, 1'b1, 100, 100, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    chk("pending_before_rst", WW'(win_valid), WW'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_win_valid", WW'(win_valid), '0);
    chk("async_rst_frame_done", WW'(frame_done), '0);
    chk("async_rst_win", win, '0);
    q.delete();
    mrow = 0; mcol = 0; fd_pend = 1'b0; prev_stall = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    clear_counts();
    send_frame(77, W*H, 1'b0, 100, 100, 1'b0);
    drain();
    chki("post_rst_windows", win_cnt, 484);
    chki("post_rst_last", last_cnt, 1);
    chki("post_rst_frame_done", fd_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 7x7 convolution core.
- Accepts a raster-scan 8-bit pixel stream, one pixel per cycle, and buffers K-1 image lines.
- Emits every stride-1 KxK window as one flat word, packed exactly as the core's image-operand bus.
- Windows are held under a valid/ready handshake so the core's enable/valid cadence can backpressure the stream.

Parameters:
- IMG_W, 28, image width in pixels (>= K)
- IMG_H, 28, image height in pixels (>= K)
- K, 7, window edge; the output carries K*K pixels
- PW, 8, pixel width in bits

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- pix_in  in  PW  input pixel
- pix_valid  in  1  pix_in is valid this cycle
- pix_sof  in  1  qualified by pix_valid; this pixel is (row 0, col 0) of a new frame
- pix_ready  out  1  block accepts a pixel this cycle
- win  out  K*K*PW  window; element i=r*K+c sits at bits [i*PW +: PW]; r=0 is the top row, c=0 the leftmost column
- win_valid  out  1  win holds an unconsumed window
- win_ready  in  1  downstream consumes win this cycle
- win_last  out  1  qualified by win_valid; this is the last window of the frame
- frame_done  out  1  one-cycle pulse, the cycle after the frame's last pixel is accepted

Behaviour:
- Accept = pix_valid && pix_ready.
- pix_ready = !win_valid || win_ready (combinational); no pixel is accepted while an unconsumed window would be overwritten.
- Reset values: win_valid=0, win=0, win_last=0, frame_done=0, row/col counters=0, window register array=0. Line-buffer RAM contents are not reset.
- Counters:
  - col increments on each accept and wraps IMG_W-1 -> 0.
  - On wrap, row increments; row wraps IMG_H-1 -> 0 on the last pixel of the frame.
  - An accepted pixel with pix_sof=1 is forced to position (0,0); the counters continue from there. This also applies mid-frame, where it silently resyncs.
- Line buffers: K-1 lines of IMG_W x PW. On accept, the pixel enters the newest line and each line's column output cascades to the next older line.
- Window shift array (KxK): on accept, every row shifts one column left. The new rightmost column is rows 0..K-2 from the line-buffer outputs (oldest at top) and row K-1 = pix_in.
- Window emit:
  - If the accepted pixel has row >= K-1 and col >= K-1, the updated array is loaded into win and win_valid=1 on the next edge. Latency is 1 cycle from accepting the window's bottom-right pixel.
  - win_last=1 with that window iff the pixel is (IMG_H-1, IMG_W-1).
- Handshake:
  - win_valid is cleared when win_valid && win_ready and no new window loads that cycle.
  - A load in the same cycle as a consume keeps win_valid=1 with the new data.
  - win, win_valid and win_last are stable while win_valid && !win_ready.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1), which is 484 at defaults. No windows straddle row wrap or frame boundary.
- Frame structure:
  - frame_done is asserted exactly once per frame, independent of win_ready.
  - The next frame may start the cycle after the last pixel with no gap.
- Reset mid-frame:
  - Outputs drop immediately (asynchronous).
  - After release, the first accepted pixel is (0,0) regardless of pix_sof.
  - Stale line-buffer data is never emitted, because windows require row >= K-1 of the current frame.
- Arithmetic: counters are sized clog2(IMG_W) and clog2(IMG_H); no pixel arithmetic, data is passed bit-exact.

Test Plan:
- Ramp frame: pixel(r,c)=(r*28+c) mod 256, win_ready=1, no bubbles -> exactly 484 windows.
  - First window is emitted 1 cycle after accepting (6,6), the 175th pixel, with element0=0, element6=6, element7=28, element48=174.
  - Every window matches a software 7x7 crop.
- Backpressure: hold win_ready=0 for 10 cycles at the first window -> pix_ready=0 and win stable for all 10 cycles, no pixel lost; all 484 windows are still correct.
- Random bubbles: pix_valid 50% random, win_ready 30% random -> window sequence identical to the ramp case; win_valid never drops without a consume.
- Back-to-back frames: two frames, second with a pix_sof pulse and a different ramp offset.
  - win_last accompanies only window (27,27) of each frame.
  - frame_done pulses once per frame, 1 cycle after the last pixel.
  - Second-frame windows contain no first-frame data.
- Mid-frame pix_sof after 100 pixels -> counters resync to (0,0); the first window follows 174 accepts later.
- Reset asserted after 300 pixels with a window pending -> win_valid=0 and frame_done=0 asynchronously; the following full frame yields 484 correct windows.
